// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin scheduler and stage sequencer for a shared FP add datapath
//
// Purpose: grants one requester at a time (round-robin from a rotating pointer),
// registers its operand pair toward the datapath, pulses the align/add/normalize
// stage enables in turn, latches the normalized result and returns it with the
// requester index.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_a/req_b    per-requester request and packed IEEE-754 operands (lane i = [32*i+31:32*i])
//   req_ready                one-hot grant, only while idle
//   dp_a/dp_b                operands held toward the datapath
//   dp_align_en/dp_add_en/dp_norm_en  one-cycle stage enables
//   dp_result                normalized result, valid the cycle after dp_norm_en
//   resp_valid/resp_id/resp_result/resp_ready  response handshake
//   busy                     high whenever an operation is in flight
//
// Optional feature (macro FP_SCHED_ZERO_BYPASS_EN): operations with a zero operand
// skip the datapath and respond directly from the accept cycle.

module fp_add_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           dp_a,
    output logic [31:0]           dp_b,
    output logic                  dp_align_en,
    output logic                  dp_add_en,
    output logic                  dp_norm_en,
    input  logic [31:0]           dp_result,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    input  logic                  resp_ready,
    output logic                  busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] WB    = 3'd4;
    localparam logic [2:0] RESP  = 3'd5;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic [2:0]         state;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] valid_rot;
    logic               found;
    logic [ID_W:0]      pick_sum;
    logic [ID_W-1:0]    grant_id;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W:0]      ptr_inc;
    logic [ID_W-1:0]    ptr_next;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic               accept;

    // Rotate the request vector so bit 0 is the lane the pointer names; the
    // lowest set bit of the rotated vector is the round-robin winner. Scanning
    // downward lets the lowest offset win without an early exit.
    always_comb begin
        valid_rot = NUM_REQ'({req_valid, req_valid} >> ptr);
        found     = 1'b0;
        pick_sum  = {1'b0, ptr};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                found    = 1'b1;
                pick_sum = {1'b0, ptr} + (ID_W+1)'(k);
            end
        end
        if (pick_sum >= NUM_REQ_W) begin
            pick_sum = pick_sum - NUM_REQ_W;
        end
        grant_id = pick_sum[ID_W-1:0];
        grant    = found ? (NUM_REQ'(1) << grant_id) : '0;
        ptr_inc  = {1'b0, grant_id} + (ID_W+1)'(1);
        ptr_next = (ptr_inc == NUM_REQ_W) ? '0 : ptr_inc[ID_W-1:0];
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

`ifdef FP_SCHED_ZERO_BYPASS_EN
    // Zero means +/-0 only; denormals with a nonzero fraction go through the datapath.
    logic        a_zero;
    logic        b_zero;
    logic        bypass;
    logic [31:0] bypass_result;

    always_comb begin
        a_zero = (sel_a[30:0] == 31'd0);
        b_zero = (sel_b[30:0] == 31'd0);
        bypass = a_zero | b_zero;
        if (a_zero && b_zero) begin
            bypass_result = {sel_a[31] & sel_b[31], 31'd0};
        end else if (a_zero) begin
            bypass_result = sel_b;
        end else begin
            bypass_result = sel_a;
        end
    end
`endif

    assign accept = (state == IDLE) && found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            dp_a        <= '0;
            dp_b        <= '0;
            resp_id     <= '0;
            resp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_a    <= sel_a;
                        dp_b    <= sel_b;
                        resp_id <= grant_id;
                        ptr     <= ptr_next;
`ifdef FP_SCHED_ZERO_BYPASS_EN
                        if (bypass) begin
                            resp_result <= bypass_result;
                            state       <= RESP;
                        end else begin
                            state <= ALIGN;
                        end
`else
                        state <= ALIGN;
`endif
                    end
                end
                ALIGN: state <= ADD;
                ADD:   state <= NORM;
                NORM:  state <= WB;
                WB: begin
                    resp_result <= dp_result;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the grant so req_ready reads zero while rst is held, even
    // though the state already sits in IDLE.
    assign req_ready   = (state == IDLE && !rst) ? grant : '0;
    assign dp_align_en = (state == ALIGN);
    assign dp_add_en   = (state == ADD);
    assign dp_norm_en  = (state == NORM);
    assign resp_valid  = (state == RESP);
    assign busy        = (state != IDLE);

endmodule
